// File: rtl/axi4_lite_pkg.sv
// Shared types and defaults for the AXI4-Lite read master and its block-fill sequencer.
package axi4_lite_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 64;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } t_fill_state;

  // Byte offset of word cnt inside a block.
  function automatic logic [DEF_ADDR_WIDTH-1:0] word_offset(input int unsigned cnt,
                                                            input int unsigned word_bytes);
    return DEF_ADDR_WIDTH'(cnt) * DEF_ADDR_WIDTH'(word_bytes);
  endfunction

endpackage

// File: rtl/axi4_lite_block_fill.sv
// Cache-block fill sequencer: turns one block request into WORDS single-word reads,
// assembles the returned words and hands the block to the cache.
module axi4_lite_block_fill
  import axi4_lite_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned AXI_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BLOCK_WIDTH    = 512
) (
  input  logic                      clk_i,
  input  logic                      arstn_i,
  input  logic                      req_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr_i,
  output logic                      req_ready_o,
  output logic                      blk_valid_o,
  input  logic                      blk_ready_i,
  output logic [BLOCK_WIDTH-1:0]    blk_data_o,
  output logic                      blk_fault_o,
  output logic                      rd_start_o,
  output logic [AXI_ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [AXI_DATA_WIDTH-1:0] rd_data_i,
  input  logic                      rd_fault_i,
  input  logic                      rd_done_i
);

  localparam int unsigned WORDS      = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int unsigned CNT_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned OFF_W      = $clog2(BLOCK_WIDTH / 8);
  localparam int unsigned WORD_BYTES = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] BLK_MASK =
    ~((AXI_ADDR_WIDTH'(1) << OFF_W) - AXI_ADDR_WIDTH'(1));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  t_fill_state               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] base_q, base_d;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [BLOCK_WIDTH-1:0]    blk_data_q, blk_data_d;
  logic                      blk_fault_q, blk_fault_d;
  logic                      blk_valid_q, blk_valid_d;
  logic                      rd_start_q, rd_start_d;
  logic                      live_q;

  // Ready only once out of reset so req_ready_o reads 0 while reset is held.
  assign req_ready_o = (state_q == IDLE) && live_q;
  assign blk_valid_o = blk_valid_q;
  assign blk_data_o  = blk_data_q;
  assign blk_fault_o = blk_fault_q;
  assign rd_start_o  = rd_start_q;
  assign rd_addr_o   = rd_addr_q;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    rd_addr_d   = rd_addr_q;
    blk_data_d  = blk_data_q;
    blk_fault_d = blk_fault_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && live_q) begin
          state_d     = ISSUE;
          base_d      = req_addr_i & BLK_MASK;
          rd_addr_d   = req_addr_i & BLK_MASK;
          cnt_d       = '0;
          blk_fault_d = 1'b0;
          blk_data_d  = '0;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (rd_done_i) begin
          blk_data_d[32'(cnt_q) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = rd_data_i;
          blk_fault_d = blk_fault_q | rd_fault_i;
          if (rd_fault_i || (cnt_q == LAST_CNT)) begin
            state_d = DONE;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            rd_addr_d = base_q + AXI_ADDR_WIDTH'(word_offset(32'(cnt_d), WORD_BYTES));
            state_d   = ISSUE;
          end
        end
      end
      DONE: begin
        if (blk_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_start_d  = (state_d == ISSUE);
    blk_valid_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      rd_addr_q   <= '0;
      blk_data_q  <= '0;
      blk_fault_q <= 1'b0;
      blk_valid_q <= 1'b0;
      rd_start_q  <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      rd_addr_q   <= rd_addr_d;
      blk_data_q  <= blk_data_d;
      blk_fault_q <= blk_fault_d;
      blk_valid_q <= blk_valid_d;
      rd_start_q  <= rd_start_d;
      live_q      <= 1'b1;
    end
  end

endmodule
